// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU (C) and debug (D).
// One transaction at a time; a watchdog aborts a silent memory with err.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   input  logic [3:0]    c_be,
   output logic          c_ack,
   output logic [DW-1:0] c_rdata,
   output logic          c_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   input  logic [3:0]    d_be,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          d_err,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic          busy
);

   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic            r_owner;
   logic            r_last;
   logic            r_we;
   logic [AW-1:0]   r_addr;
   logic [DW-1:0]   r_wdata;
   logic [3:0]      r_be;
   logic [CW-1:0]   r_cnt;
   logic            r_err;
   logic [DW-1:0]   r_c_rdata;
   logic [DW-1:0]   r_d_rdata;

   logic            w_any;
   logic            w_gnt_d;
   logic            w_tmo;
   logic            w_resp;

   // owner/last_gnt encoding: 0 = C, 1 = D; on a tie the port not last served wins
   assign w_any   = c_req | d_req;
   assign w_gnt_d = d_req & (~c_req | ~r_last);
   assign w_tmo   = (r_cnt == CW'(TIMEOUT - 1));
   assign w_resp  = (r_state == S_RESP);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_next = S_WAIT;
         end
         S_WAIT: begin
            if (mem_ack || w_tmo) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner   <= 1'b0;
         r_last    <= 1'b1;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_be      <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_c_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner <= w_gnt_d;
                  r_last  <= w_gnt_d;
                  r_err   <= 1'b0;
                  r_we    <= w_gnt_d ? d_we    : c_we;
                  r_addr  <= w_gnt_d ? d_addr  : c_addr;
                  r_wdata <= w_gnt_d ? d_wdata : c_wdata;
                  r_be    <= w_gnt_d ? d_be    : c_be;
               end
            end
            S_ISSUE: begin
               r_cnt <= '0;
            end
            S_WAIT: begin
               if (mem_ack) begin
                  r_err <= 1'b0;
                  if (!r_we) begin
                     if (r_owner) begin
                        r_d_rdata <= mem_rdata;
                     end else begin
                        r_c_rdata <= mem_rdata;
                     end
                  end
               end else if (w_tmo) begin
                  r_err <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ack/err decode from state so an async reset drops them immediately
   assign c_ack     = w_resp & ~r_owner;
   assign d_ack     = w_resp &  r_owner;
   assign c_err     = c_ack & r_err;
   assign d_err     = d_ack & r_err;
   assign c_rdata   = r_c_rdata;
   assign d_rdata   = r_d_rdata;

   assign mem_en    = (r_state == S_ISSUE);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign mem_be    = r_be;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// hand-written contention, stray-ack, reset and request-drop sequences.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic [3:0]  c_be, d_be;
   logic        c_ack, c_err, d_ack, d_err;
   logic [31:0] c_rdata, d_rdata;
   logic        mem_en, mem_we, mem_ack, busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_be(c_be), .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
      .mem_ack(mem_ack), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        port_d;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          dly;
      logic [31:0] mrd;
      int          exp_lat;
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int en_cnt, en_cyc, lat, oth_cnt;
      logic own_ack, oth_ack, own_err;
      logic [31:0] own_rd;
      en_cnt = 0; en_cyc = -1; lat = -1; oth_cnt = 0;
      @(negedge clk);
      if (v.port_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr;
         d_wdata = v.wdata; d_be = v.be;
      end else begin
         c_req = 1'b1; c_we = v.we; c_addr = v.addr;
         c_wdata = v.wdata; c_be = v.be;
      end
      for (int cyc = 1; cyc <= 40 && lat < 0; cyc++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         mem_rdata = 32'hFFFF_FFFF;
         if (mem_en) begin
            en_cnt++;
            en_cyc = cyc;
            check($sformatf("v%0d mem_addr", idx), mem_addr, v.addr);
            check($sformatf("v%0d mem_we", idx), mem_we, v.we);
            check($sformatf("v%0d mem_be", idx), mem_be, v.be);
            if (v.we) check($sformatf("v%0d mem_wdata", idx), mem_wdata, v.wdata);
         end
         if (en_cyc > 0 && v.dly > 0 && cyc == en_cyc + v.dly) begin
            mem_ack = 1'b1;
            mem_rdata = v.mrd;
         end
         own_ack = v.port_d ? d_ack : c_ack;
         oth_ack = v.port_d ? c_ack : d_ack;
         own_err = v.port_d ? d_err : c_err;
         own_rd  = v.port_d ? d_rdata : c_rdata;
         if (oth_ack) oth_cnt++;
         if (own_ack) begin
            lat = cyc;
            check($sformatf("v%0d err", idx), own_err, v.exp_err);
            check($sformatf("v%0d rdata", idx), own_rd, v.exp_rd);
            c_req = 1'b0;
            d_req = 1'b0;
         end
      end
      mem_ack = 1'b0;
      c_req = 1'b0;
      d_req = 1'b0;
      check($sformatf("v%0d ack latency", idx), lat, v.exp_lat);
      check($sformatf("v%0d mem_en count", idx), en_cnt, 1);
      check($sformatf("v%0d other ack", idx), oth_cnt, 0);
   endtask

   initial begin
      int grants, acks, idle_low, en_cnt, en_cyc;
      logic prev_en, started, found;

      //             port we  addr          wdata         be     dly mrd           lat err rd
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        4'hF,  1, 32'h8C22_0004, 3,  1'b0, 32'h8C22_0004};
      vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3, 5, 32'hA5A5_A5A5, 7,  1'b0, 32'h0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,        4'hF,  2, 32'h1234_5678, 4,  1'b0, 32'h1234_5678};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_0001, 4'hC, 3, 32'hA5A5_A5A5, 5,  1'b0, 32'h8C22_0004};
      vecs[4] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0,        4'hF,  0, 32'h0,         18, 1'b1, 32'h8C22_0004};
      vecs[5] = '{1'b0, 1'b0, 32'h0000_004C, 32'h0,        4'hF,  1, 32'h0BAD_F00D, 3,  1'b0, 32'h0BAD_F00D};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,        4'hF,  0, 32'h0,         18, 1'b1, 32'h1234_5678};

      reset = 1'b0;
      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_be = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      mem_ack = 0; mem_rdata = 0;
      repeat (3) @(negedge clk);
      check("rst busy", busy, 0);
      check("rst mem_en", mem_en, 0);
      check("rst mem_we", mem_we, 0);
      check("rst mem_addr", mem_addr, 0);
      check("rst mem_wdata", mem_wdata, 0);
      check("rst mem_be", mem_be, 0);
      check("rst c_ack", c_ack, 0);
      check("rst d_ack", d_ack, 0);
      check("rst c_err", c_err, 0);
      check("rst d_err", d_err, 0);
      check("rst c_rdata", c_rdata, 0);
      check("rst d_rdata", d_rdata, 0);
      reset = 1'b1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // stray acks while idle must change nothing
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         mem_ack = 1'b1;
         mem_rdata = 32'h7777_7777;
         check("stray busy", busy, 0);
         check("stray ack", {c_ack, d_ack}, 2'b00);
      end
      @(negedge clk);
      mem_ack = 1'b0;
      check("stray busy after", busy, 0);
      check("stray c_rdata", c_rdata, 32'h0BAD_F00D);
      check("stray d_rdata", d_rdata, 32'h1234_5678);

      // contention: both held, grants alternate C, D, C, D
      c_we = 0; d_we = 0; c_addr = 32'h10; d_addr = 32'h20;
      c_req = 1; d_req = 1;
      grants = 0; acks = 0; idle_low = 0; prev_en = 0; started = 0;
      for (int cyc = 0; cyc < 60 && acks < 4; cyc++) begin
         @(negedge clk);
         mem_ack = prev_en;
         mem_rdata = 32'h0000_1000 + 32'(cyc);
         prev_en = mem_en;
         if (mem_en) begin
            check($sformatf("grant %0d", grants), mem_addr,
                  (grants % 2 == 0) ? 32'h10 : 32'h20);
            grants++;
            started = 1;
         end
         if (started && !busy) idle_low++;
         if (c_ack || d_ack) acks++;
         if (acks == 4) begin
            c_req = 0;
            d_req = 0;
         end
      end
      mem_ack = 0;
      c_req = 0; d_req = 0;
      check("contention grants", grants, 4);
      check("contention acks", acks, 4);
      check("contention idle cycles", idle_low, 3);

      // reset during WAIT
      @(negedge clk);
      c_addr = 32'h80; d_addr = 32'h90;
      c_req = 1; d_req = 1;
      @(negedge clk);
      check("rmid issue en", mem_en, 1);
      check("rmid issue addr", mem_addr, 32'h80);
      @(negedge clk);
      check("rmid wait busy", busy, 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("rmid busy", busy, 0);
      check("rmid mem_en", mem_en, 0);
      check("rmid acks", {c_ack, d_ack}, 2'b00);
      @(negedge clk);
      reset = 1'b1;
      found = 0;
      for (int cyc = 0; cyc < 10 && !found; cyc++) begin
         @(negedge clk);
         if (mem_en) begin
            found = 1;
            check("rmid reissue addr", mem_addr, 32'h80);
            d_req = 0;
         end
      end
      check("rmid reissue seen", found, 1);
      @(negedge clk);
      mem_ack = 1; mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_ack = 0;
      check("rmid c_ack", c_ack, 1);
      check("rmid c_rdata", c_rdata, 32'h5555_AAAA);
      c_req = 0;

      // request dropped during WAIT
      @(negedge clk);
      c_addr = 32'hC0; c_we = 0; c_req = 1;
      acks = 0; en_cnt = 0; en_cyc = -1;
      for (int cyc = 1; cyc <= 15; cyc++) begin
         @(negedge clk);
         mem_ack = 0;
         if (mem_en) begin
            en_cnt++;
            en_cyc = cyc;
         end
         if (en_cyc > 0 && cyc == en_cyc + 1) c_req = 0;
         if (en_cyc > 0 && cyc == en_cyc + 3) begin
            mem_ack = 1;
            mem_rdata = 32'h1357_2468;
         end
         if (c_ack) acks++;
      end
      mem_ack = 0;
      check("drop ack count", acks, 1);
      check("drop mem_en count", en_cnt, 1);
      check("drop busy", busy, 0);
      check("drop c_rdata", c_rdata, 32'h1357_2468);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters:
  - Port C: the multi-cycle CPU datapath (fetch and load/store states).
  - Port D: the debug/program loader.
- Arbitrates round-robin, issues one memory transaction at a time, and tracks completion with a timeout watchdog.
- Returns read data and an error flag to the winning requester. The CPU's controller holds its fetch/memory state until its port acknowledges.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- TIMEOUT, 16, maximum WAIT cycles before a transaction is aborted with error. Must be at least 2.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset. 0 resets all state immediately.
- c_req  in  1  port C request. Held with its fields until c_ack.
- c_we  in  1  port C write enable (1 = write, 0 = read).
- c_addr  in  AW  port C byte address.
- c_wdata  in  DW  port C write data.
- c_be  in  4  port C byte enables.
- c_ack  out  1  port C one-cycle completion pulse.
- c_rdata  out  DW  port C read data, valid with c_ack.
- c_err  out  1  port C timeout flag, valid with c_ack.
- d_req, d_we, d_addr, d_wdata, d_be, d_ack, d_rdata, d_err: identical set for port D.
- mem_en  out  1  memory command strobe, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  DW  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, at the earliest one cycle after mem_en.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - state = IDLE, last_gnt = D (so C wins the first tie), wait counter = 0.
  - All outputs 0, including both rdata buses and all latched command fields.
- States:
  - IDLE:
    - If neither port requests, stay in IDLE.
    - If exactly one port requests, it wins.
    - If both request, the port not equal to last_gnt wins.
    - Latch the winner's we/addr/wdata/be, record the winner in owner and last_gnt, then go to ISSUE.
  - ISSUE:
    - mem_en = 1 for exactly this cycle, with the latched fields on the mem_* outputs.
    - Clear the counter and go to WAIT.
    - mem_ack in this cycle is ignored.
  - WAIT:
    - mem_en = 0; the mem_* fields stay at the latched values.
    - If mem_ack: latch mem_rdata (reads only; writes leave owner rdata unchanged), set err = 0, go to RESP.
    - Else if counter == TIMEOUT-1: set err = 1, leave rdata unchanged, go to RESP.
    - Else increment the counter.
  - RESP:
    - Pulse owner's ack for one cycle, with owner's err valid.
    - The non-owner's ack and err stay 0.
    - Go to IDLE.
- Latency: with a zero-wait memory, req seen in cycle N gives mem_en in N+1, mem_ack in N+2, and requester ack in N+3. The earliest next arbitration is N+4.
- err is registered alongside ack and cleared on the next transaction for that port. rdata holds until the owner's next successful read.
- Requester drops req mid-transaction: the transaction still completes and ack still pulses. The requester must tolerate this.
- req still high in IDLE after ack is treated as a new request.
- Stray mem_ack outside WAIT, including a late ack after a timeout, is ignored with no state change.
- Round-robin fairness: under continuous requests from both ports, grants strictly alternate C, D, C, D.
- Reset asserted mid-transaction:
  - mem_en, ack and busy drop asynchronously.
  - State returns to IDLE and the pending transaction is lost with no ack.
- The counter width must hold TIMEOUT-1 without wrap.

Test Plan:
- Single read: c_req with c_addr=0x00000040, c_we=0; memory acks 1 cycle after mem_en with rdata=0x8C220004 -> mem_en=1 exactly once with mem_addr=0x40; c_ack pulses 3 cycles after req; c_rdata=0x8C220004; c_err=0; d_ack stays 0.
- Contention: c_req and d_req rise together and are held for 4 transactions -> grant order C, D, C, D; busy never drops between back-to-back grants for more than the IDLE cycle.
- Write with wait states: d_req, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=4'b0011; memory acks 5 cycles after mem_en -> mem_we=1, mem_be=0011; d_ack arrives 7 cycles after req; d_rdata is unchanged.
- Timeout: TIMEOUT=16, memory never acks -> c_ack and c_err=1 exactly 16 WAIT cycles after ISSUE. A later stray mem_ack is ignored. The next read with a normal ack returns c_err=0.
- Reset mid-op: assert reset during WAIT -> mem_en, busy and acks are 0 in the same cycle. After release with c_req held, a fresh ISSUE occurs and C wins.
- Request drop: c_req deasserted during WAIT -> c_ack still pulses once, then the arbiter returns to IDLE.
